// File: rtl/hamming_stream_decoder_if.sv
// Stream bundle between a Hamming codeword source and the decoder: input word handshake,
// corrected output handshake, and the error-counter side band.
interface hamming_stream_decoder_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
);
    localparam int PAR_W  = (DATA_W + 4 <= 8)  ? 3 :
                            (DATA_W + 5 <= 16) ? 4 :
                            (DATA_W + 6 <= 32) ? 5 : 6;
`ifdef HAMMING_DEC_SECDED_EN
    localparam int CODE_W = DATA_W + PAR_W + 1;
`else
    localparam int CODE_W = DATA_W + PAR_W;
`endif

    logic [0:CODE_W-1] code_in;
    logic              in_valid;
    logic              in_ready;
    logic [0:DATA_W-1] data_out;
    logic [PAR_W-1:0]  syndrome;
    logic              err_corr;
    logic              err_uncorr;
    logic              out_valid;
    logic              out_ready;
    logic              cnt_clr;
    logic [CNT_W-1:0]  corr_cnt;
    logic [CNT_W-1:0]  uncorr_cnt;

    modport master (
        output code_in, in_valid, out_ready, cnt_clr,
        input  in_ready, data_out, syndrome, err_corr, err_uncorr, out_valid,
        input  corr_cnt, uncorr_cnt
    );

    modport slave (
        input  code_in, in_valid, out_ready, cnt_clr,
        output in_ready, data_out, syndrome, err_corr, err_uncorr, out_valid,
        output corr_cnt, uncorr_cnt
    );
endinterface

// File: rtl/hamming_stream_decoder.sv
// Streaming Hamming SEC decoder with saturating error counters; SECDED when HAMMING_DEC_SECDED_EN.
// Latency: 2 cycles (S1 = codeword + syndrome, S2 = corrected payload + flags).
// Backpressure: out_ready stalls S2, a full S1 behind a stalled S2 drops in_ready the same cycle.
module hamming_stream_decoder #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    hamming_stream_decoder_if.slave   bus
);
    localparam int PAR_W  = (DATA_W + 4 <= 8)  ? 3 :
                            (DATA_W + 5 <= 16) ? 4 :
                            (DATA_W + 6 <= 32) ? 5 : 6;
    localparam int HAM_W  = DATA_W + PAR_W;
`ifdef HAMMING_DEC_SECDED_EN
    localparam int CODE_W = HAM_W + 1;
`else
    localparam int CODE_W = HAM_W;
`endif

    logic en1;
    logic en2;

    logic              s1_valid_q, s1_valid_d;
    logic [0:CODE_W-1] s1_code_q,  s1_code_d;
    logic [PAR_W-1:0]  s1_syn_q,   s1_syn_d;
    logic [PAR_W-1:0]  syn_c;
`ifdef HAMMING_DEC_SECDED_EN
    logic              s1_par_q,   s1_par_d;
`endif

    logic              out_valid_q, out_valid_d;
    logic [0:DATA_W-1] data_q,      data_d;
    logic [PAR_W-1:0]  syn_q,       syn_d;
    logic              corr_q,      corr_d;
    logic              uncorr_q,    uncorr_d;
    logic [CNT_W-1:0]  corr_cnt_q,  corr_cnt_d;
    logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;

    logic [0:DATA_W-1] data_c;
    logic              corr_c;
    logic              uncorr_c;
    logic              fix_c;
    logic              in_range_c;

    // Syndrome excludes the overall-parity bit so a clean SECDED word still yields zero.
    always_comb begin
        syn_c = '0;
        for (int k = 0; k < PAR_W; k++) begin
            for (int i = 0; i < HAM_W; i++) begin
                if ((((i + 1) >> k) & 1) != 0) begin
                    syn_c[k] = syn_c[k] ^ bus.code_in[i];
                end
            end
        end
    end

    always_comb begin
        int j;
        corr_c     = 1'b0;
        uncorr_c   = 1'b0;
        fix_c      = 1'b0;
        in_range_c = (s1_syn_q != '0) && (int'(s1_syn_q) <= HAM_W);
`ifdef HAMMING_DEC_SECDED_EN
        if (s1_syn_q == '0) begin
            corr_c = s1_par_q;
        end else if (s1_par_q && in_range_c) begin
            corr_c = 1'b1;
            fix_c  = 1'b1;
        end else begin
            uncorr_c = 1'b1;
        end
`else
        if (s1_syn_q == '0) begin
            corr_c = 1'b0;
        end else if (in_range_c) begin
            corr_c = 1'b1;
            fix_c  = 1'b1;
        end else begin
            uncorr_c = 1'b1;
        end
`endif
        // Payload sits in the non-power-of-two positions; parity positions are dropped.
        j      = 0;
        data_c = '0;
        for (int i = 0; i < HAM_W; i++) begin
            if (((i + 1) & i) != 0) begin
                data_c[j] = s1_code_q[i] ^ (fix_c && ((i + 1) == int'(s1_syn_q)));
                j++;
            end
        end
    end

    always_comb begin
        en2 = !out_valid_q || bus.out_ready;
        en1 = !s1_valid_q || en2;

        s1_valid_d = s1_valid_q;
        s1_code_d  = s1_code_q;
        s1_syn_d   = s1_syn_q;
`ifdef HAMMING_DEC_SECDED_EN
        s1_par_d   = s1_par_q;
`endif
        if (en1) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_code_d = bus.code_in;
                s1_syn_d  = syn_c;
`ifdef HAMMING_DEC_SECDED_EN
                s1_par_d  = ^bus.code_in;
`endif
            end
        end

        out_valid_d = out_valid_q;
        data_d      = data_q;
        syn_d       = syn_q;
        corr_d      = corr_q;
        uncorr_d    = uncorr_q;
        if (en2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                data_d   = data_c;
                syn_d    = s1_syn_q;
                corr_d   = corr_c;
                uncorr_d = uncorr_c;
            end
        end

        // Clear wins over a coincident increment; counters stick at all-ones.
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (bus.cnt_clr) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else if (out_valid_q && bus.out_ready) begin
            if (corr_q && (corr_cnt_q != {CNT_W{1'b1}})) begin
                corr_cnt_d = corr_cnt_q + CNT_W'(1);
            end
            if (uncorr_q && (uncorr_cnt_q != {CNT_W{1'b1}})) begin
                uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_code_q    <= '0;
            s1_syn_q     <= '0;
`ifdef HAMMING_DEC_SECDED_EN
            s1_par_q     <= 1'b0;
`endif
            out_valid_q  <= 1'b0;
            data_q       <= '0;
            syn_q        <= '0;
            corr_q       <= 1'b0;
            uncorr_q     <= 1'b0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_code_q    <= s1_code_d;
            s1_syn_q     <= s1_syn_d;
`ifdef HAMMING_DEC_SECDED_EN
            s1_par_q     <= s1_par_d;
`endif
            out_valid_q  <= out_valid_d;
            data_q       <= data_d;
            syn_q        <= syn_d;
            corr_q       <= corr_d;
            uncorr_q     <= uncorr_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign bus.in_ready   = en1;
    assign bus.out_valid  = out_valid_q;
    assign bus.data_out   = data_q;
    assign bus.syndrome   = syn_q;
    assign bus.err_corr   = corr_q;
    assign bus.err_uncorr = uncorr_q;
    assign bus.corr_cnt   = corr_cnt_q;
    assign bus.uncorr_cnt = uncorr_cnt_q;
endmodule

// File: tb/tb_hamming_stream_decoder.sv
// Bench for hamming_stream_decoder (DATA_W=16, CNT_W=4): directed cases plus random traffic
// scored against a position-XOR reference decoder.
module tb_hamming_stream_decoder;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;
    localparam int PAR_W  = 5;
    localparam int HAM_W  = DATA_W + PAR_W;
`ifdef HAMMING_DEC_SECDED_EN
    localparam int CODE_W = HAM_W + 1;
`else
    localparam int CODE_W = HAM_W;
`endif

    typedef struct packed {
        logic [0:DATA_W-1] data;
        logic [PAR_W-1:0]  syn;
        logic              corr;
        logic              uncorr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hamming_stream_decoder_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
    hamming_stream_decoder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    int   exp_corr    = 0;
    int   exp_uncorr  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [0:CODE_W-1] encode(input logic [0:DATA_W-1] d);
        logic [0:CODE_W-1] c;
        int j;
        int s;
        c = '0;
        j = 0;
        for (int p = 1; p <= HAM_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p-1] = d[j];
                j++;
            end
        end
        s = 0;
        for (int p = 1; p <= HAM_W; p++) if (c[p-1]) s = s ^ p;
        for (int k = 0; k < PAR_W; k++) if (((s >> k) & 1) != 0) c[(1 << k) - 1] = 1'b1;
`ifdef HAMMING_DEC_SECDED_EN
        c[CODE_W-1] = ^c;
`endif
        return c;
    endfunction

    function automatic exp_t decode(input logic [0:CODE_W-1] c);
        exp_t e;
        int s;
        int j;
        logic par;
        logic [0:CODE_W-1] f;
        s = 0;
        for (int p = 1; p <= HAM_W; p++) if (c[p-1]) s = s ^ p;
        par      = ^c;
        f        = c;
        e.syn    = s[PAR_W-1:0];
        e.corr   = 1'b0;
        e.uncorr = 1'b0;
`ifdef HAMMING_DEC_SECDED_EN
        if (s == 0) e.corr = par;
        else if (par && s <= HAM_W) begin e.corr = 1'b1; f[s-1] = ~f[s-1]; end
        else e.uncorr = 1'b1;
`else
        if (par === 1'bx) e.uncorr = 1'bx;
        if (s == 0) e.corr = 1'b0;
        else if (s <= HAM_W) begin e.corr = 1'b1; f[s-1] = ~f[s-1]; end
        else e.uncorr = 1'b1;
`endif
        j = 0;
        e.data = '0;
        for (int p = 1; p <= HAM_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                e.data[j] = f[p-1];
                j++;
            end
        end
        return e;
    endfunction

    // Scoreboard, counter model and stall-stability monitor.
    logic              stall_prev = 1'b0;
    logic [0:DATA_W-1] prev_data;
    logic [PAR_W-1:0]  prev_syn;
    logic              prev_corr, prev_uncorr;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            exp_corr   = 0;
            exp_uncorr = 0;
            stall_prev = 1'b0;
        end else begin
            check("corr_cnt", 64'(bus.corr_cnt), 64'(exp_corr));
            check("uncorr_cnt", 64'(bus.uncorr_cnt), 64'(exp_uncorr));
            if (stall_prev) begin
                check("stall_valid", 64'(bus.out_valid), 64'd1);
                check("stall_data", 64'(bus.data_out), 64'(prev_data));
                check("stall_flags", {bus.syndrome, bus.err_corr, bus.err_uncorr},
                      {prev_syn, prev_corr, prev_uncorr});
            end
            check("no_double_flag", 64'(bus.err_corr && bus.err_uncorr), 64'd0);
            if (bus.in_valid && bus.in_ready) exp_q.push_back(decode(bus.code_in));
            if (bus.out_valid && bus.out_ready) begin
                check("out_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("data_out", 64'(bus.data_out), 64'(e.data));
                    check("syndrome", 64'(bus.syndrome), 64'(e.syn));
                    check("err_corr", 64'(bus.err_corr), 64'(e.corr));
                    check("err_uncorr", 64'(bus.err_uncorr), 64'(e.uncorr));
                    if (e.corr && exp_corr < (1 << CNT_W) - 1) exp_corr++;
                    if (e.uncorr && exp_uncorr < (1 << CNT_W) - 1) exp_uncorr++;
                end
            end
            if (bus.cnt_clr) begin
                exp_corr   = 0;
                exp_uncorr = 0;
            end
            stall_prev  = bus.out_valid && !bus.out_ready;
            prev_data   = bus.data_out;
            prev_syn    = bus.syndrome;
            prev_corr   = bus.err_corr;
            prev_uncorr = bus.err_uncorr;
        end
    end

    task automatic send(input logic [0:CODE_W-1] code, input bit rnd);
        logic ok;
        ok = 1'b0;
        bus.code_in  = code;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check("send_accept", 64'(ok), 64'd1);
    endtask

    task automatic wait_out();
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            seen = bus.out_valid;
        end
        check("out_valid_seen", 64'(seen), 64'd1);
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !bus.out_valid;
        end
        check("drain", 64'(done), 64'd1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [0:CODE_W-1] flip1(input logic [0:CODE_W-1] c, input int i);
        logic [0:CODE_W-1] r;
        r    = c;
        r[i] = ~r[i];
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:CODE_W-1] w [4];
        logic [0:CODE_W-1] c;
        logic [0:DATA_W-1] d;
        int k;
        int a;
        int b;
        logic acc;

        bus.code_in   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.cnt_clr   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_data", 64'(bus.data_out), 64'd0);
        check("rst_flags", {bus.syndrome, bus.err_corr, bus.err_uncorr}, 64'd0);
        check("rst_cnts", {bus.corr_cnt, bus.uncorr_cnt}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // All-zero word: out_valid rises two cycles after the accept cycle.
        send('0, 1'b0);
        @(negedge clk);
        check("lat_early", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("lat_valid", 64'(bus.out_valid), 64'd1);
        check("zero_data", 64'(bus.data_out), 64'd0);
        check("zero_flags", {bus.syndrome, bus.err_corr, bus.err_uncorr}, 64'd0);
        drain();

        d = 16'hA5C3;
        send(flip1(encode(d), 6), 1'b0);
        wait_out();
        check("single_syn", 64'(bus.syndrome), 64'd7);
        check("single_corr", {bus.err_corr, bus.err_uncorr}, 64'b10);
        check("single_data", 64'(bus.data_out), 64'hA5C3);
        @(negedge clk);
        check("single_cnt", 64'(bus.corr_cnt), 64'd1);
        drain();

        send(flip1(flip1(encode(d), 14), 15), 1'b0);
        wait_out();
        check("double_syn", 64'(bus.syndrome), 64'd31);
        check("double_flags", {bus.err_corr, bus.err_uncorr}, 64'b01);
        check("double_data", 64'(bus.data_out), 64'hA5E3);
        @(negedge clk);
        check("double_cnt", 64'(bus.uncorr_cnt), 64'd1);
        drain();

`ifdef HAMMING_DEC_SECDED_EN
        send(flip1(flip1(encode(d), 2), 4), 1'b0);
        wait_out();
        check("ded_syn", 64'(bus.syndrome), 64'd6);
        check("ded_flags", {bus.err_corr, bus.err_uncorr}, 64'b01);
        check("ded_data", 64'(bus.data_out), 64'h65C3);
        drain();
`endif

        // Back-to-back words with out_ready held low for five cycles.
        for (int i = 0; i < 4; i++) w[i] = encode(16'($urandom));
        w[1] = flip1(w[1], 9);
        bus.out_ready = 1'b0;
        k = 0;
        bus.in_valid = 1'b1;
        bus.code_in  = w[0];
        for (int cyc = 0; cyc < 60 && k < 4; cyc++) begin
            @(negedge clk);
            acc = bus.in_ready;
            if (cyc == 3) begin
                check("stall_in_ready", 64'(bus.in_ready), 64'd0);
                check("stall_accepted", 64'(k), 64'd2);
            end
            @(posedge clk);
            #1;
            if (acc) begin
                k++;
                if (k < 4) bus.code_in = w[k];
                else bus.in_valid = 1'b0;
            end
            if (cyc == 4) bus.out_ready = 1'b1;
        end
        bus.in_valid = 1'b0;
        check("stall_all_sent", 64'(k), 64'd4);
        drain();

        // Random traffic: 0, 1 or 2 flips, random backpressure and counter clears.
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            c = encode(16'($urandom));
            a = $urandom_range(0, CODE_W - 1);
            b = (a + $urandom_range(1, CODE_W - 1)) % CODE_W;
            case ($urandom_range(0, 2))
                1: c = flip1(c, a);
                2: c = flip1(flip1(c, a), b);
                default: ;
            endcase
            bus.cnt_clr = ($urandom_range(0, 19) == 0);
            send(c, 1'b1);
            bus.cnt_clr = 1'b0;
        end
        bus.out_ready = 1'b1;
        drain();

        // Counter saturation at 15.
        bus.cnt_clr = 1'b1;
        @(posedge clk);
        #1 bus.cnt_clr = 1'b0;
        for (int n = 0; n < 20; n++) send(flip1(encode(16'($urandom)), $urandom_range(0, HAM_W - 1)), 1'b0);
        drain();
        @(negedge clk);
        check("corr_sat", 64'(bus.corr_cnt), 64'd15);
        @(posedge clk);
        #1;

        // Clear coincident with a corrected word leaving the pipe.
        send(flip1(encode(16'h1234), 3), 1'b0);
        @(posedge clk);
        #1 bus.cnt_clr = 1'b1;
        @(negedge clk);
        check("clr_hs_flag", {bus.out_valid, bus.err_corr}, 64'b11);
        @(posedge clk);
        #1 bus.cnt_clr = 1'b0;
        @(negedge clk);
        check("clr_priority", 64'(bus.corr_cnt), 64'd0);
        drain();

        // Reset with words in flight.
        bus.out_ready = 1'b0;
        send(flip1(encode(16'hBEEF), 5), 1'b0);
        send(encode(16'h0F0F), 1'b0);
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_cnts", {bus.corr_cnt, bus.uncorr_cnt}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        send(encode(16'h5A5A), 1'b0);
        wait_out();
        check("post_rst_data", 64'(bus.data_out), 64'h5A5A);
        drain();
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hamming_stream_decoder.md
HAMMING_STREAM_DECODER -- requirements
Module: hamming_stream_decoder

Interface
REQ-001 SHALL have parameter DATA_W, default 16, payload bits per word; legal range 4..57.
REQ-002 SHALL have parameter CNT_W, default 16, width of each error counter; legal range 2..32.
REQ-003 SHALL derive localparams as fixed parameters:
- PAR_W: smallest r with 2^r >= DATA_W+r+1.
- CODE_W: DATA_W+PAR_W, plus 1 when HAMMING_DEC_SECDED_EN is defined.
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 code_in  input  [0:CODE_W-1]  codeword; index i holds Hamming position i+1.
REQ-008 in_valid  input  1  code_in valid.
REQ-009 in_ready  output  1  decoder accepts a word this cycle.
REQ-010 data_out  output  [0:DATA_W-1]  corrected payload, non-power-of-two positions in ascending order.
REQ-011 syndrome  output  [PAR_W-1:0]  raw syndrome of the word.
REQ-012 err_corr  output  1  single-bit error corrected.
REQ-013 err_uncorr  output  1  uncorrectable error.
REQ-014 out_valid  input/output: output  1  data_out and flags valid.
REQ-015 out_ready  input  1  downstream accepts.
REQ-016 cnt_clr  input  1  synchronous clear of both counters.
REQ-017 corr_cnt, uncorr_cnt  output  [CNT_W-1:0] each  saturating error counters.

Function
REQ-018 SHALL use two pipeline stages: S1 registers code_in and syndrome; S2 registers data_out and flags.
REQ-019 SHALL have latency 2 cycles, from the accepting edge to out_valid, when unstalled.
REQ-020 SHALL sustain 1 word/cycle throughput when out_ready=1.
REQ-021 SHALL drive en2 = !out_valid | out_ready, en1 = !s1_valid | en2, and in_ready = en1 (combinational).
REQ-022 SHALL accept a word only on in_valid & in_ready.
REQ-023 SHALL hold out_valid, data_out and flags stable while out_valid & !out_ready.
REQ-024 SHALL never drop, duplicate or reorder words.
REQ-025 SHALL compute syndrome bit k as the XOR of code_in indices i where bit k of (i+1) is 1, parity bits included.
REQ-026 SEC mode, syndrome=0: SHALL pass data through with no flags.
REQ-027 SEC mode, 1<=syndrome<=CODE_W: SHALL invert position syndrome and assert err_corr.
REQ-028 SEC mode, syndrome>CODE_W: SHALL assert err_uncorr and pass data uncorrected.
REQ-029 SHALL never assert err_corr and err_uncorr together.
REQ-030 SHALL correct a flipped parity position by setting err_corr, with data_out unchanged.
REQ-031 SHALL update counters only on an output handshake (out_valid & out_ready):
- corr_cnt +1 if err_corr.
- uncorr_cnt +1 if err_uncorr.
REQ-032 SHALL hold each counter at 2^CNT_W-1 once saturated.
REQ-033 cnt_clr SHALL zero both counters next edge, taking priority over a simultaneous increment.

Reset
REQ-034 On rst, SHALL asynchronously clear:
- s1_valid and out_valid.
- data_out, syndrome, err_corr and err_uncorr to 0.
- corr_cnt and uncorr_cnt to 0.
REQ-035 In-flight words SHALL be discarded on reset.
REQ-036 in_ready SHALL read 1 in the first cycle after rst deasserts.

Configuration
REQ-037 Macro HAMMING_DEC_SECDED_EN defined: SHALL enable SECDED decoding:
- code_in[CODE_W-1] is the overall parity of all other bits.
- P = XOR of all CODE_W bits.
- syndrome=0, P=0: clean.
- syndrome=0, P=1: err_corr, overall bit only.
- syndrome in range, P=1: correct, err_corr.
- syndrome!=0, P=0: err_uncorr, no correction.
- syndrome out of range, P=1: err_uncorr.
REQ-038 Macro undefined: SHALL use SEC-only rules REQ-026..028; no overall-parity bit, no extra logic.

Verification (DATA_W=16, PAR_W=5, CODE_W=21 SEC / 22 SECDED)
REQ-039 All-zero codeword, out_ready=1 -> data_out=0, syndrome=0, no flags, out_valid exactly 2 cycles after accept.
REQ-040 Valid codeword of data 0xA5C3, index 6 flipped -> syndrome=7, err_corr=1, data_out=0xA5C3, corr_cnt=1.
REQ-041 SEC mode: indices 14 and 15 flipped -> syndrome=31, err_uncorr=1, data uncorrected, uncorr_cnt=1.
REQ-042 SECDED mode: indices 2 and 4 flipped -> syndrome=6, err_uncorr=1, err_corr=0, data uncorrected.
REQ-043 out_ready low 5 cycles while sending 4 words back-to-back -> in_ready low after 2 accepted; all 4 emerge in order, once each.
REQ-044 CNT_W=4, 20 single-error words -> corr_cnt=15; cnt_clr with a coincident error -> 0; rst mid-stream -> out_valid=0 immediately.
